// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out frame transmitter, LSB first, one bit per enabled clk.
// Build option PISO_PARITY_EN appends an even-parity bit after data bit WIDTH-1.
module piso_tx #(
  parameter int WIDTH = 144,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             en,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_W = WIDTH + 1;
`else
  localparam int FRAME_W = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               out_q, out_d;
  logic [FRAME_W-1:0] load_frame;
  logic [FRAME_W-1:0] shifted;
  logic               last_bit;

  // The transmitted frame is the data word, optionally topped with its even parity.
`ifdef PISO_PARITY_EN
  assign load_frame = {^load_data, load_data};
`else
  assign load_frame = load_data;
`endif

  // out_q always mirrors shreg_q[0], so the next bit is bit 1 of the current register.
  assign shifted    = shreg_q >> 1;
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || (last_bit && en);
  assign done       = last_bit && en;
  assign out        = out_q;
  assign out_valid  = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = load_frame;
          out_d   = load_frame[0];
        end
      end

      SHIFT: begin
        if (en) begin
          if (cnt_q == LAST) begin
            if (load_valid) begin
              // Back-to-back frame: bit 0 of the new frame follows without a gap.
              cnt_d   = '0;
              shreg_d = load_frame;
              out_d   = load_frame[0];
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              shreg_d = '0;
              out_d   = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = shifted;
            out_d   = shifted[0];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the shift register is cleared too, so an aborted frame can never
      // leak bits into the next one.
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
    end
  end

`ifndef SYNTHESIS
  cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= LAST);
  idle_is_quiet: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> (cnt_q == '0 && !out_q));
  out_tracks_shreg: assert property (@(posedge clk) disable iff (rst)
    (state_q == SHIFT) |-> (out_q == shreg_q[0]));
`endif

endmodule
